// File: rtl/evm_pkg.sv
// Shared definitions for the voting machine: channel indices,
// ballot FSM state encoding and small vote helpers.
package evm_pkg;

    localparam int NUM_CHAN = 6;

    localparam int IDX_P1   = 0;
    localparam int IDX_P2   = 1;
    localparam int IDX_P3   = 2;
    localparam int IDX_P4   = 3;
    localparam int IDX_P5   = 4;
    localparam int IDX_NOTA = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEBOUNCE,
        ST_CAST,
        ST_WAIT_RELEASE
    } evm_ballot_state_t;

    function automatic logic multi_press(input logic [NUM_CHAN-1:0] v);
        return $countones(v) > 1;
    endfunction

endpackage

// File: rtl/ballot_unit_btn_sync.sv
// Two-flop synchroniser for raw asynchronous button inputs.
// Cleared together with the rest of the ballot unit.
module btn_sync #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ballot_unit.sv
// Per-voter front end: debounces candidate buttons and emits one
// single-cycle vote pulse per officer-issued ballot.
module ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                CLEAR_N,
    input  logic                ENABLE,
    input  logic [NUM_CHAN-1:0] BTN,
    output logic                READY,
    output logic                INVALID,
    output logic                P1,
    output logic                P2,
    output logic                P3,
    output logic                P4,
    output logic                P5,
    output logic                NOTA
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CHAN-1:0] w_sbtn;
    evm_ballot_state_t   r_state;
    evm_ballot_state_t   w_next;
    logic [CW-1:0]       r_cnt;
    logic [NUM_CHAN-1:0] r_sel;
    logic [NUM_CHAN-1:0] r_out;
    logic                w_stable;
    logic                w_ready;
    logic                w_invalid;

    btn_sync #(
        .W (NUM_CHAN)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (CLEAR_N),
        .i_d     (BTN),
        .o_q     (w_sbtn)
    );

    assign w_stable = (w_sbtn == r_sel);

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ENABLE && (w_sbtn == '0)) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if ($onehot(w_sbtn)) w_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!w_stable) begin
                    w_next = ST_ARMED;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = ST_CAST;
                end
            end
            ST_CAST: begin
                w_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (w_sbtn == '0) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        w_invalid = 1'b0;
        unique case (r_state)
            ST_ARMED: begin
                w_ready   = 1'b1;
                w_invalid = multi_press(w_sbtn);
            end
            ST_DEBOUNCE: w_ready = 1'b1;
            default: ;
        endcase
    end

    // Counter stops at CNT_LAST because the FSM leaves DEBOUNCE there.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_cnt <= '0;
            r_sel <= '0;
            r_out <= '0;
        end else begin
            unique case (r_state)
                ST_ARMED: begin
                    if ($onehot(w_sbtn)) begin
                        r_sel <= w_sbtn;
                        r_cnt <= '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_out <= r_sel;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_CAST: r_out <= '0;
                default: ;
            endcase
        end
    end

    assign READY   = w_ready;
    assign INVALID = w_invalid;
    assign P1      = r_out[IDX_P1];
    assign P2      = r_out[IDX_P2];
    assign P3      = r_out[IDX_P3];
    assign P4      = r_out[IDX_P4];
    assign P5      = r_out[IDX_P5];
    assign NOTA    = r_out[IDX_NOTA];

endmodule
